// File: rtl/cavlc_field_serializer.sv
// cavlc_field_serializer
//   Serializes the CAVLC syntax fields of one block (coeff_token,
//   trailing_ones_sign, levels, total_zeros, run_before) into a single
//   MSB-first bitstream. Fields go out in ascending index order, and
//   zero-length fields are skipped without costing a cycle.
//
// Ports
//   CLK, RST     clock, synchronous active-high reset
//   in_valid     block fields present on field_code/field_len
//   in_ready     block can be accepted (IDLE only)
//   field_code   packed codewords, field i at [i*CODE_W +: CODE_W], right-justified
//   field_len    packed lengths, field i at [i*LEN_W +: LEN_W]
//   out_ready    downstream accepts a bit this cycle
//   CAVLC_out    serial bitstream bit
//   out_valid    CAVLC_out carries a bit
//   field_sel    index of the field owning the current bit
//   blk_done     one-cycle pulse at block end
//   bits_total   bits emitted for the last completed block
module cavlc_field_serializer #(
  parameter int NUM_FIELDS = 5,
  parameter int CODE_W     = 16,
  parameter int LEN_W      = 5,
  parameter int SEL_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*CODE_W-1:0] field_code,
  input  logic [NUM_FIELDS*LEN_W-1:0]  field_len,
  input  logic                         out_ready,
  output logic                         CAVLC_out,
  output logic                         out_valid,
  output logic [SEL_W-1:0]             field_sel,
  output logic                         blk_done,
  output logic [15:0]                  bits_total
);

  localparam int PTR_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  // Captured block
  logic [CODE_W-1:0] code_r [NUM_FIELDS];
  logic [LEN_W-1:0]  len_r  [NUM_FIELDS];
  logic [15:0]       total_r;

  // Current bit position
  logic [SEL_W-1:0]  sel_r;
  logic [PTR_W-1:0]  bit_r;

  // Input-side lookahead
  logic [LEN_W-1:0]  cl_len [NUM_FIELDS];
  logic [15:0]       in_total;
  logic              first_found;
  logic [SEL_W-1:0]  first_idx;

  // Next nonzero field after the current one
  logic              next_found;
  logic [SEL_W-1:0]  next_idx;

  logic              accept;
  logic              xfer;
  logic              last_bit;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (32'(l) > CODE_W) return LEN_W'(CODE_W);
    return l;
  endfunction

  always_comb begin
    in_total    = '0;
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      cl_len[i] = clamp_len(field_len[i*LEN_W +: LEN_W]);
      in_total  = in_total + 16'(cl_len[i]);
    end
    // Scan downward so the lowest nonzero index wins.
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (cl_len[i] != '0) begin
        first_found = 1'b1;
        first_idx   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if ((len_r[i] != '0) && (i > int'(sel_r))) begin
        next_found = 1'b1;
        next_idx   = SEL_W'(i);
      end
    end
  end

  assign accept   = (state == IDLE) && in_valid;
  assign xfer     = (state == SHIFT) && out_ready;
  assign last_bit = (bit_r == '0) && !next_found;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = first_found ? SHIFT : DONE;
      SHIFT:   if (out_ready && last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST)                     bits_total <= '0;
    else if (state_nxt == DONE && state != DONE)
      bits_total <= (state == IDLE) ? in_total : total_r;
  end

  // Capture stage: block registered on acceptance, later input changes ignored.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        code_r[i] <= field_code[i*CODE_W +: CODE_W];
        len_r[i]  <= cl_len[i];
      end
      total_r <= in_total;
      sel_r   <= first_idx;
      bit_r   <= PTR_W'(cl_len[first_idx] - 1'b1);
    end else if (xfer) begin
      // Shift stage: step down within a field, then jump to the next nonzero one.
      if (bit_r != '0) begin
        bit_r <= bit_r - 1'b1;
      end else if (next_found) begin
        sel_r <= next_idx;
        bit_r <= PTR_W'(len_r[next_idx] - 1'b1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SHIFT);
  assign CAVLC_out = (state == SHIFT) ? code_r[sel_r][bit_r] : 1'b0;
  assign field_sel = (state == SHIFT) ? sel_r : '0;
  assign blk_done  = (state == DONE);

endmodule

// File: tb/tb_cavlc_field_serializer.sv
module tb_cavlc_field_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] field_code;
  logic [24:0] field_len;
  logic        out_ready;
  logic        cavlc_bit;
  logic        out_valid;
  logic [2:0]  field_sel;
  logic        blk_done;
  logic [15:0] bits_total;

  cavlc_field_serializer dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .field_code(field_code), .field_len(field_len),
    .out_ready(out_ready),
    .CAVLC_out(cavlc_bit), .out_valid(out_valid),
    .field_sel(field_sel), .blk_done(blk_done), .bits_total(bits_total)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];   // {bit, sel}
  int         tot_q[$];

  logic       hold_chk = 1'b0;
  logic       hold_bit;
  logic [2:0] hold_sel;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every transferred bit and every blk_done against the queues.
  always @(negedge clk) begin
    if (hold_chk) begin
      chk("hold_bit", int'(cavlc_bit), int'(hold_bit));
      chk("hold_sel", int'(field_sel), int'(hold_sel));
      hold_chk = 1'b0;
    end
    if (out_valid) begin
      if (!out_ready) begin
        hold_chk = 1'b1;
        hold_bit = cavlc_bit;
        hold_sel = field_sel;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("bit", int'(cavlc_bit), int'(e[3]));
        chk("sel", int'(field_sel), int'(e[2:0]));
      end
    end
    if (blk_done) begin
      chk("done_no_valid", int'(out_valid), 0);
      if (tot_q.size() == 0) chk("unexpected_blk_done", 1, 0);
      else chk("bits_total", int'(bits_total), tot_q.pop_front());
    end
  end

  task automatic push_bit(input int b, input int s);
    exp_q.push_back({1'(b), 3'(s)});
  endtask

  // Drive one block for a single acceptance cycle; returns at posedge+1 after acceptance.
  task automatic send(input logic [79:0] c, input logic [24:0] l);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    field_code = c;
    field_len  = l;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    field_code = {5{16'hA5C3}};   // later input changes must not matter
    field_len  = {5{5'd7}};
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tot_q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", int'(n < 300), 1);
  endtask

  function automatic logic [79:0] pack_c(input logic [15:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  function automatic logic [24:0] pack_l(input logic [4:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  int bas_bits[11] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0};
  int bas_sels[11] = '{0, 1, 2, 2, 2, 3, 3, 3, 3, 4, 4};
  logic [79:0] bas_c;
  logic [24:0] bas_l;

  task automatic push_basic();
    for (int i = 0; i < 11; i++) push_bit(bas_bits[i], bas_sels[i]);
    tot_q.push_back(11);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    field_code = '0; field_len = '0;
    bas_c = pack_c(16'h0001, 16'hFFF0, 16'h0003, 16'h0005, 16'h0002);
    bas_l = pack_l(5'd1, 5'd1, 5'd3, 5'd4, 5'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cavlc", int'(cavlc_bit), 0);
    chk("rst_field_sel", int'(field_sel), 0);
    chk("rst_blk_done", int'(blk_done), 0);
    chk("rst_bits_total", int'(bits_total), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic block; first bit must be present the cycle after acceptance.
    push_basic();
    send(bas_c, bas_l);
    chk("first_bit_latency", int'(out_valid), 1);
    chk("busy_in_ready", int'(in_ready), 0);
    wait_drain();
    chk("total_held", int'(bits_total), 11);

    // Skipped fields, junk in codes of zero-length fields.
    push_bit(1, 0); push_bit(0, 0);
    push_bit(0, 3); push_bit(0, 3); push_bit(1, 3);
    tot_q.push_back(5);
    send(pack_c(16'h0002, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF),
         pack_l(5'd2, 5'd0, 5'd0, 5'd3, 5'd0));
    wait_drain();

    // All-zero lengths: DONE directly after the acceptance cycle.
    tot_q.push_back(0);
    send(pack_c(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), '0);
    chk("zero_blk_done", int'(blk_done), 1);
    chk("zero_no_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("zero_back_idle", int'(in_ready), 1);
    chk("zero_done_pulse", int'(blk_done), 0);
    wait_drain();

    // Backpressure mid field 3: three stalled cycles.
    push_basic();
    send(bas_c, bas_l);
    repeat (6) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_drain();

    // Clamp: length 31 on a 16-bit field.
    for (int i = 0; i < 16; i++) push_bit(1, 0);
    tot_q.push_back(16);
    send(pack_c(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0),
         pack_l(5'd31, 5'd0, 5'd0, 5'd0, 5'd0));
    wait_drain();

    // Reset while the fourth bit is on the output.
    push_basic();
    send(bas_c, bas_l);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    tot_q.delete();
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_cavlc", int'(cavlc_bit), 0);
    chk("abort_field_sel", int'(field_sel), 0);
    chk("abort_blk_done", int'(blk_done), 0);
    chk("abort_bits_total", int'(bits_total), 0);
    push_basic();
    send(bas_c, bas_l);
    wait_drain();

    repeat (3) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
